mtimer: RTL and testbench

Memory-mapped machine timer that replaces the free-running overflow counter as the source of `timer_intr` into the interrupt decoder, which feeds the CSR file. It holds a 64-bit `mtime`, a 64-bit `mtimecmp`, a programmable prescaler and a control register. Software reaches these registers through the same `cs`/`rd`/`mask` data-memory port style that the load/store unit drives. It raises a level interrupt while `mtime >= mtimecmp` and interrupts are enabled.

---
 rtl/mtimer_pkg.sv | 34 +++
 rtl/mtimer_prescaler.sv | 64 ++++++
 rtl/mtimer.sv | 141 ++++++++++++++
 tb/tb_mtimer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mtimer_pkg.sv
// Shared definitions for the memory-mapped machine timer: register offsets,
// CTRL bit positions, prescaler state encoding and a byte-merge helper.
package mtimer_pkg;

    localparam logic [4:0] MTIMER_MTIME_LO    = 5'h00;
    localparam logic [4:0] MTIMER_MTIME_HI    = 5'h04;
    localparam logic [4:0] MTIMER_MTIMECMP_LO = 5'h08;
    localparam logic [4:0] MTIMER_MTIMECMP_HI = 5'h0C;
    localparam logic [4:0] MTIMER_CTRL        = 5'h10;
    localparam logic [4:0] MTIMER_PRESCALE    = 5'h14;

    localparam int unsigned CTRL_EN = 0;
    localparam int unsigned CTRL_IE = 1;

    typedef enum logic {
        PS_IDLE,
        PS_COUNT
    } ps_state_e;

    // Replace each byte of old_val whose enable is set with the matching byte of wdata.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mtimer_prescaler.sv
// Prescaler for the machine timer: divides the clock by (prescale_i + 1) while
// counting is enabled and emits a single-cycle tick at the end of each period.
module mtimer_prescaler
    import mtimer_pkg::*;
#(
    parameter int unsigned PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    // EN value that takes effect at the coming edge, so state_q tracks CTRL.EN exactly
    input  logic                  en_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    input  logic                  clr_i,
    output logic                  tick_o
);

    ps_state_e             state_q, state_d;
    logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;

    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        tick_o  = 1'b0;
        unique case (state_q)
            PS_IDLE: begin
                pcnt_d = '0;
                if (en_i) begin
                    state_d = PS_COUNT;
                end
            end
            PS_COUNT: begin
                if (pcnt_q == prescale_i) begin
                    tick_o = 1'b1;
                    pcnt_d = '0;
                end else begin
                    pcnt_d = pcnt_q + PRESCALE_W'(1);
                end
                if (!en_i) begin
                    state_d = PS_IDLE;
                    pcnt_d  = '0;
                end
            end
            default: begin
                state_d = PS_IDLE;
                pcnt_d  = '0;
            end
        endcase
        // A new period length restarts the count from zero.
        if (clr_i) begin
            pcnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= PS_IDLE;
            pcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
        end
    end

endmodule

// File: rtl/mtimer.sv
// Memory-mapped machine timer: 64-bit mtime/mtimecmp, prescaled counting and a
// registered level interrupt while mtime >= mtimecmp with IE set.
module mtimer
    import mtimer_pkg::*;
#(
    parameter int unsigned PRESCALE_W   = 16,
    parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        rd,
    input  logic [4:0]  addr,
    input  logic [31:0] data_wr,
    input  logic [3:0]  mask,
    output logic [31:0] data_rd,
    output logic        valid,
    output logic        timer_intr
);

    logic [63:0]           mtime_q, mtime_d;
    logic [63:0]           mtimecmp_q, mtimecmp_d;
    logic [1:0]            ctrl_q, ctrl_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [31:0]           hi_shadow_q, hi_shadow_d;
    logic                  timer_intr_q, timer_intr_d;

    logic [4:0] word_addr;
    logic       wr_en, rd_en;
    logic       wr_mtime_lo, wr_mtime_hi, wr_cmp_lo, wr_cmp_hi, wr_ctrl, wr_prescale;
    logic       rd_mtime_lo;
    logic       tick;
    logic       unused_addr_bits;

    assign unused_addr_bits = ^addr[1:0];
    assign word_addr        = {addr[4:2], 2'b00};
    assign wr_en            = cs & ~rd;
    assign rd_en            = cs & rd;

    assign wr_mtime_lo = wr_en && (word_addr == MTIMER_MTIME_LO);
    assign wr_mtime_hi = wr_en && (word_addr == MTIMER_MTIME_HI);
    assign wr_cmp_lo   = wr_en && (word_addr == MTIMER_MTIMECMP_LO);
    assign wr_cmp_hi   = wr_en && (word_addr == MTIMER_MTIMECMP_HI);
    assign wr_ctrl     = wr_en && (word_addr == MTIMER_CTRL);
    assign wr_prescale = wr_en && (word_addr == MTIMER_PRESCALE);
    assign rd_mtime_lo = rd_en && (word_addr == MTIMER_MTIME_LO);

    mtimer_prescaler #(
        .PRESCALE_W(PRESCALE_W)
    ) u_prescaler (
        .clk       (clk),
        .reset     (reset),
        .en_i      (ctrl_d[CTRL_EN]),
        .prescale_i(prescale_q),
        .clr_i     (wr_prescale),
        .tick_o    (tick)
    );

    always_comb begin
        mtime_d      = mtime_q;
        mtimecmp_d   = mtimecmp_q;
        ctrl_d       = ctrl_q;
        prescale_d   = prescale_q;
        hi_shadow_d  = hi_shadow_q;
        timer_intr_d = ctrl_q[CTRL_IE] & (mtime_q >= mtimecmp_q);

        // A software write to either half of mtime overrides the tick for all 64 bits.
        if (wr_mtime_lo || wr_mtime_hi) begin
            if (wr_mtime_lo) begin
                mtime_d[31:0] = merge_bytes(mtime_q[31:0], data_wr, mask);
            end
            if (wr_mtime_hi) begin
                mtime_d[63:32] = merge_bytes(mtime_q[63:32], data_wr, mask);
            end
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end

        if (wr_cmp_lo) begin
            mtimecmp_d[31:0] = merge_bytes(mtimecmp_q[31:0], data_wr, mask);
        end
        if (wr_cmp_hi) begin
            mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], data_wr, mask);
        end

        if (wr_ctrl && mask[0]) begin
            ctrl_d[CTRL_EN] = data_wr[CTRL_EN];
            ctrl_d[CTRL_IE] = data_wr[CTRL_IE];
        end

        if (wr_prescale) begin
            for (int i = 0; i < int'(PRESCALE_W); i++) begin
                if (mask[i/8]) begin
                    prescale_d[i] = data_wr[i];
                end
            end
        end

        // Latch the high word on a low-word read so a LO-then-HI pair is coherent.
        if (rd_mtime_lo) begin
            hi_shadow_d = mtime_q[63:32];
        end
    end

    always_comb begin
        data_rd = '0;
        if (cs) begin
            unique case (word_addr)
                MTIMER_MTIME_LO:    data_rd = mtime_q[31:0];
                MTIMER_MTIME_HI:    data_rd = hi_shadow_q;
                MTIMER_MTIMECMP_LO: data_rd = mtimecmp_q[31:0];
                MTIMER_MTIMECMP_HI: data_rd = mtimecmp_q[63:32];
                MTIMER_CTRL:        data_rd = {30'd0, ctrl_q};
                MTIMER_PRESCALE:    data_rd[PRESCALE_W-1:0] = prescale_q;
                default:            data_rd = '0;
            endcase
        end
    end

    assign valid      = cs;
    assign timer_intr = timer_intr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mtime_q      <= '0;
            mtimecmp_q   <= MTIMECMP_RST;
            ctrl_q       <= '0;
            prescale_q   <= '0;
            hi_shadow_q  <= '0;
            timer_intr_q <= 1'b0;
        end else begin
            mtime_q      <= mtime_d;
            mtimecmp_q   <= mtimecmp_d;
            ctrl_q       <= ctrl_d;
            prescale_q   <= prescale_d;
            hi_shadow_q  <= hi_shadow_d;
            timer_intr_q <= timer_intr_d;
        end
    end

endmodule

// File: tb/tb_mtimer.sv
// Self-checking bench for mtimer: reset/readback table, directed multi-cycle
// sequences, and randomized register traffic against a behavioural model.
module tb_mtimer;

    localparam int unsigned PW = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cs = 1'b0;
    logic        rd = 1'b0;
    logic [4:0]  addr = '0;
    logic [31:0] data_wr = '0;
    logic [3:0]  mask = '0;
    logic [31:0] data_rd;
    logic        valid;
    logic        timer_intr;

    always #5 clk = ~clk;

    mtimer #(
        .PRESCALE_W  (PW),
        .MTIMECMP_RST(64'hFFFF_FFFF_FFFF_FFFF)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cs        (cs),
        .rd        (rd),
        .addr      (addr),
        .data_wr   (data_wr),
        .mask      (mask),
        .data_rd   (data_rd),
        .valid     (valid),
        .timer_intr(timer_intr)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        cs;
        logic        rd;
        logic [4:0]  addr;
        logic [31:0] exp_rd;
        logic        exp_valid;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // All bus tasks start and end just after a falling edge.
    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] m);
        cs = 1'b1; rd = 1'b0; addr = a; data_wr = d; mask = m;
        @(negedge clk);
        cs = 1'b0; mask = '0;
    endtask

    task automatic rdreg(input logic [4:0] a, output logic [31:0] d);
        cs = 1'b1; rd = 1'b1; addr = a;
        #1 d = data_rd;
        @(negedge clk);
        cs = 1'b0; rd = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        cs = 1'b0; rd = 1'b0; reset = 1'b0;
        idle(2);
        reset = 1'b1;
        idle(1);
    endtask

    // ---------------- behavioural model ----------------
    logic [63:0] m_time, m_cmp;
    logic [15:0] m_psc;
    logic [31:0] m_shadow;
    bit          m_en, m_ie, m_intr;
    int unsigned m_cnt;

    function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n,
                                           input logic [3:0] m);
        logic [31:0] me;
        me = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
        return (o & ~me) | (n & me);
    endfunction

    function automatic logic [31:0] model_read(input int w);
        case (w)
            0: return m_time[31:0];
            1: return m_shadow;
            2: return m_cmp[31:0];
            3: return m_cmp[63:32];
            4: return {30'd0, m_ie, m_en};
            5: return {16'd0, m_psc};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_init();
        m_time = '0; m_cmp = '1; m_psc = '0; m_shadow = '0;
        m_en = 0; m_ie = 0; m_intr = 0; m_cnt = 0;
    endtask

    // Advance the model across one clock edge using the bus request of that cycle.
    task automatic model_step(input bit c, input bit r, input int w, input logic [31:0] d,
                              input logic [3:0] m);
        bit          tick, nxt_intr, psc_wr, old_en;
        logic [63:0] nt;
        logic [31:0] tmp;
        old_en   = m_en;
        tick     = m_en && ((m_cnt % (32'(m_psc) + 1)) == 32'(m_psc));
        nxt_intr = m_ie && (m_time >= m_cmp);
        psc_wr   = 0;
        if (c && r && w == 0) m_shadow = m_time[63:32];
        nt = tick ? m_time + 64'd1 : m_time;
        if (c && !r) begin
            case (w)
                0: nt = {m_time[63:32], bmerge(m_time[31:0], d, m)};
                1: nt = {bmerge(m_time[63:32], d, m), m_time[31:0]};
                2: m_cmp[31:0] = bmerge(m_cmp[31:0], d, m);
                3: m_cmp[63:32] = bmerge(m_cmp[63:32], d, m);
                4: if (m[0]) begin m_en = d[0]; m_ie = d[1]; end
                5: begin tmp = bmerge({16'd0, m_psc}, d, m); m_psc = tmp[15:0]; psc_wr = 1; end
                default: ;
            endcase
        end
        if (psc_wr || !m_en) m_cnt = 0;
        else if (old_en) m_cnt++;
        m_time = nt;
        m_intr = nxt_intr;
    endtask

    initial begin
        logic [31:0] v;

        vecs[0] = '{1'b1, 1'b1, 5'h00, 32'h0000_0000, 1'b1};
        vecs[1] = '{1'b1, 1'b1, 5'h04, 32'h0000_0000, 1'b1};
        vecs[2] = '{1'b1, 1'b1, 5'h08, 32'hFFFF_FFFF, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 5'h0C, 32'hFFFF_FFFF, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 5'h10, 32'h0000_0000, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 5'h14, 32'h0000_0000, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 5'h18, 32'h0000_0000, 1'b1};
        vecs[7] = '{1'b1, 1'b1, 5'h1C, 32'h0000_0000, 1'b1};
        vecs[8] = '{1'b0, 1'b1, 5'h08, 32'h0000_0000, 1'b0};
        vecs[9] = '{1'b1, 1'b1, 5'h0B, 32'hFFFF_FFFF, 1'b1};

        do_reset();

        // Count with an interrupt pending, then pull reset mid-cycle.
        wr(5'h0C, 32'h0, 4'hF);
        wr(5'h08, 32'h0, 4'hF);
        wr(5'h10, 32'h3, 4'hF);
        idle(5);
        chk("pre_reset_intr", timer_intr, 1'b1);
        cs = 1'b1; rd = 1'b1; addr = 5'h00;
        #1 chk("pre_reset_mtime", data_rd, 32'd5);
        #2 reset = 1'b0;
        #1 chk("async_reset_mtime", data_rd, 32'd0);
        chk("async_reset_intr", timer_intr, 1'b0);
        idle(1);
        cs = 1'b0; rd = 1'b0;
        idle(1);
        reset = 1'b1;
        idle(1);

        for (int i = 0; i < 10; i++) begin
            cs = vecs[i].cs; rd = vecs[i].rd; addr = vecs[i].addr;
            #1;
            chk($sformatf("reset_rd[%0d]", i), data_rd, vecs[i].exp_rd);
            chk($sformatf("reset_valid[%0d]", i), valid, vecs[i].exp_valid);
            chk($sformatf("reset_intr[%0d]", i), timer_intr, 1'b0);
            @(negedge clk);
        end
        cs = 1'b0; rd = 1'b0;

        // Prescaler: PRESCALE=3 gives one tick per 4 cycles.
        do_reset();
        wr(5'h14, 32'd3, 4'hF);
        wr(5'h10, 32'd1, 4'hF);
        idle(3);
        rdreg(5'h00, v);
        chk("psc_before_first_tick", v, 32'd0);
        idle(36);
        rdreg(5'h00, v);
        chk("psc_after_40", v, 32'd10);

        // Carry into HI and coherent LO/HI read.
        do_reset();
        wr(5'h04, 32'h0, 4'hF);
        wr(5'h00, 32'hFFFF_FFFE, 4'hF);
        wr(5'h10, 32'd1, 4'hF);
        idle(2);
        rdreg(5'h00, v);
        chk("carry_lo", v, 32'h0);
        rdreg(5'h04, v);
        chk("carry_hi", v, 32'h1);
        wr(5'h00, 32'hFFFF_FFF0, 4'hF);
        rdreg(5'h00, v);
        chk("shadow_lo", v, 32'hFFFF_FFF0);
        idle(20);
        rdreg(5'h04, v);
        chk("shadow_hi_held", v, 32'h1);

        // Interrupt rise and clear.
        do_reset();
        wr(5'h0C, 32'h0, 4'hF);
        wr(5'h08, 32'd20, 4'hF);
        wr(5'h10, 32'd3, 4'hF);
        idle(20);
        chk("intr_at_mtime20", timer_intr, 1'b0);
        idle(1);
        chk("intr_rise", timer_intr, 1'b1);
        wr(5'h08, 32'd100, 4'hF);
        chk("intr_old_cmp", timer_intr, 1'b1);
        idle(1);
        chk("intr_cleared", timer_intr, 1'b0);

        // Masked write on a tick cycle wins over the increment.
        do_reset();
        wr(5'h00, 32'h1234_5600, 4'hF);
        wr(5'h10, 32'd1, 4'hF);
        idle(4);
        wr(5'h00, 32'hFFFF_FF55, 4'b0001);
        rdreg(5'h00, v);
        chk("collide_write", v, 32'h1234_5655);
        rdreg(5'h00, v);
        chk("collide_next_tick", v, 32'h1234_5656);

        // Wrap from all-ones to zero drops the interrupt.
        do_reset();
        wr(5'h0C, 32'h0, 4'hF);
        wr(5'h08, 32'd5, 4'hF);
        wr(5'h04, 32'hFFFF_FFFF, 4'hF);
        wr(5'h00, 32'hFFFF_FFFF, 4'hF);
        wr(5'h10, 32'd3, 4'hF);
        chk("wrap_intr_pre", timer_intr, 1'b0);
        idle(1);
        chk("wrap_intr_high", timer_intr, 1'b1);
        rdreg(5'h00, v);
        chk("wrap_lo", v, 32'h0);
        chk("wrap_intr_drop", timer_intr, 1'b0);
        rdreg(5'h04, v);
        chk("wrap_hi", v, 32'h0);

        // Randomized traffic against the model.
        do_reset();
        model_init();
        for (int n = 0; n < 1500; n++) begin
            int          kind, w;
            logic [31:0] d, exp;
            logic [3:0]  m;
            kind = $urandom_range(0, 9);
            w    = $urandom_range(0, 7);
            d    = '0;
            m    = '0;
            if (kind < 3) begin
                cs = 1'b0; rd = 1'($urandom);
            end else if (kind < 6) begin
                cs = 1'b1; rd = 1'b1;
            end else begin
                cs = 1'b1; rd = 1'b0;
                m  = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
                case (w)
                    0, 2:    d = $urandom_range(0, 300);
                    1, 3:    d = $urandom_range(0, 1);
                    4:       d = ($urandom & 32'hFFFF_FFFC) | (($urandom_range(0, 4) != 0) ? 32'd1 : 32'd0)
                                 | 32'($urandom_range(0, 1) << 1);
                    5:       d = $urandom_range(0, 3);
                    default: d = $urandom;
                endcase
            end
            addr = {3'(w), 2'($urandom)};
            data_wr = d;
            mask = m;
            #1;
            exp = (cs && rd) ? model_read(w) : 32'd0;
            if (!cs || rd) chk("rand_rd", data_rd, exp);
            chk("rand_valid", valid, cs);
            chk("rand_intr", timer_intr, m_intr);
            model_step(cs, rd, w, d, m);
            @(negedge clk);
        end
        cs = 1'b0; rd = 1'b0; mask = '0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
